regfile_wb_scheduler: RTL

- Sequences the integer register file's single write port and tracks pending destination registers.
- Accepts destination reservations from issue and arbitrates two writeback sources onto one registered write port: src0 is execute/ALU, src1 is memory load.
- Exports per-register busy status so issue can stall RAW/WAW hazards.
- Busy clears only when the register file has committed the value, so the file's 1-cycle synchronous read returns new data.

---
 rtl/regfile_wb_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler and destination scoreboard: two writeback sources share one
// registered write port, busy bits track pending destinations. Define WB_RR_ARB_EN for round-robin arbitration.
module regfile_wb_scheduler #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            src0_valid,
    input  logic [AW-1:0]   src0_rd,
    input  logic [DW-1:0]   src0_data,
    output logic            src0_ready,
    input  logic            src1_valid,
    input  logic [AW-1:0]   src1_rd,
    input  logic [DW-1:0]   src1_data,
    output logic            src1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            wb_unexp
);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    logic      grant0, grant1;
    wb_req_t   win;
    logic      wr_en;
    logic      iss_set;
    logic [NREG-1:0] busy_nxt;

`ifdef WB_RR_ARB_EN
    // rr_ptr=0 favours src1, rr_ptr=1 favours src0; it flips to the loser after every grant
    logic rr_ptr;

    assign grant1 = src1_valid & (~src0_valid | ~rr_ptr);

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (grant1)
            rr_ptr <= 1'b1;
        else if (grant0)
            rr_ptr <= 1'b0;
    end
`else
    assign grant1 = src1_valid;
`endif

    assign grant0     = src0_valid & ~grant1;
    assign src0_ready = grant0;
    assign src1_ready = grant1;

    assign win   = grant1 ? '{rd: src1_rd, data: src1_data} : '{rd: src0_rd, data: src0_data};
    assign wr_en = (grant0 | grant1) & (win.rd != '0);

    // No bypass: busy stays visible until the edge after the file commits the value
    assign iss_ready = ~busy[iss_rd] | (iss_rd == '0);
    assign rs1_busy  = busy[q_rs1] & (q_rs1 != '0);
    assign rs2_busy  = busy[q_rs2] & (q_rs2 != '0);
    assign iss_set   = iss_valid & iss_ready & (iss_rd != '0);

    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_waddr] = 1'b0;
        if (iss_set)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_unexp <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            rf_we    <= wr_en;
            wb_unexp <= rf_we & (rf_waddr != '0) & ~busy[rf_waddr];
            if (wr_en) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

endmodule
